// File: rtl/seq_pkg.sv
// Shared types and reset constants for the sequence step controller and its table.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } seq_state_e;

    localparam int SEQ_W     = 4;
    localparam int RST_COUNT = 3;
    localparam int DEF_FILL  = 5;

    // Entry i holds the successor of i: 3->0->1->5->2->7->6->4->9->12->3, others ->5.
    localparam logic [15:0][SEQ_W-1:0] DEF_NEXT = {
        4'd5, 4'd5, 4'd5, 4'd3, 4'd5, 4'd5, 4'd12, 4'd5,
        4'd6, 4'd4, 4'd2, 4'd9, 4'd0, 4'd7, 4'd5,  4'd1
    };

    localparam logic [15:0] DEF_TERM = 16'h1000;

endpackage

// File: rtl/seq_table.sv
// Next-state / terminal-flag register file: synchronous write, asynchronous read,
// reloaded with the default sequence on reset.
module seq_table
    import seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we_i,
    input  logic [W-1:0] waddr_i,
    input  logic [W-1:0] wnext_i,
    input  logic         wlast_i,
    input  logic [W-1:0] raddr_i,
    output logic [W-1:0] rnext_o,
    output logic         rlast_o
);

    localparam int DEPTH = 1 << W;

    logic [W-1:0]     next_q [DEPTH];
    logic [DEPTH-1:0] term_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                // Entries beyond the 16-entry default image fall back to the fill value.
                next_q[i] <= (i < 16) ? W'(DEF_NEXT[i[3:0]]) : W'(DEF_FILL);
                term_q[i] <= (i < 16) ? DEF_TERM[i[3:0]] : 1'b0;
            end
        end else if (we_i) begin
            next_q[waddr_i] <= wnext_i;
            term_q[waddr_i] <= wlast_i;
        end
    end

    assign rnext_o = next_q[raddr_i];
    assign rlast_o = term_q[raddr_i];

endmodule

// File: rtl/seq_step_ctrl.sv
// Run controller: walks the programmable sequence from a seed for a number of laps,
// pulsing wrap on each lap and done when the programmed laps are complete.
module seq_step_ctrl
    import seq_pkg::*;
#(
    parameter int W    = 4,
    parameter int LAPW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [W-1:0]    cfg_addr,
    input  logic [W-1:0]    cfg_next,
    input  logic            cfg_last,
    input  logic            start,
    input  logic [W-1:0]    seed,
    input  logic [LAPW-1:0] num_laps,
    input  logic            stop,
    output logic [W-1:0]    count,
    output logic            busy,
    output logic            wrap,
    output logic            done,
    output logic [LAPW-1:0] lap_cnt,
    output logic            cfg_err
);

    seq_state_e      state_q;
    logic [W-1:0]    count_q;
    logic [LAPW-1:0] lap_q;
    logic [LAPW-1:0] laps_q;
    logic            busy_q;
    logic            wrap_q;
    logic            done_q;
    logic            cfg_err_q;

    logic [W-1:0]    count_d;
    logic [LAPW-1:0] lap_d;
    logic            term_hit;
    logic            tbl_we;

    // The table is only writable while idle so a run never sees it change under it.
    assign tbl_we = cfg_we && (state_q == ST_IDLE);
    assign lap_d  = lap_q + 1'b1;

    seq_table #(.W(W)) u_table (
        .clk     (clk),
        .reset   (reset),
        .we_i    (tbl_we),
        .waddr_i (cfg_addr),
        .wnext_i (cfg_next),
        .wlast_i (cfg_last),
        .raddr_i (count_q),
        .rnext_o (count_d),
        .rlast_o (term_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= W'(RST_COUNT);
            lap_q     <= '0;
            laps_q    <= '0;
            busy_q    <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= cfg_we && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        laps_q <= num_laps;
                        if (num_laps != '0) begin
                            count_q <= seed;
                            lap_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_RUN: begin
                    // stop wins over the step that would otherwise happen this edge.
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        count_q <= count_d;
                        if (term_hit) begin
                            wrap_q <= 1'b1;
                            lap_q  <= lap_d;
                            if (lap_d == laps_q) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_FIN;
                            end
                        end
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign count   = count_q;
    assign busy    = busy_q;
    assign wrap    = wrap_q;
    assign done    = done_q;
    assign lap_cnt = lap_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Self-checking bench for seq_step_ctrl against a table-walking reference model.
module tb_seq_step_ctrl;

    localparam int W    = 4;
    localparam int LAPW = 8;

    logic            clk = 1'b0;
    logic            reset, cfg_we, cfg_last, start, stop;
    logic [W-1:0]    cfg_addr, cfg_next, seed;
    logic [LAPW-1:0] num_laps;
    logic [W-1:0]    count;
    logic            busy, wrap, done, cfg_err;
    logic [LAPW-1:0] lap_cnt;

    seq_step_ctrl #(.W(W), .LAPW(LAPW)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_next(cfg_next), .cfg_last(cfg_last), .start(start), .seed(seed),
        .num_laps(num_laps), .stop(stop), .count(count), .busy(busy),
        .wrap(wrap), .done(done), .lap_cnt(lap_cnt), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]    c;
        logic            b;
        logic            w;
        logic            d;
        logic [LAPW-1:0] l;
    } obs_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   tbl [16];
    bit   trm [16];
    int   m_count, m_lap;
    obs_t exp_q [$];

    function automatic obs_t mk(int c, bit b, bit w, bit d, int l);
        obs_t o;
        o.c = W'(c); o.b = b; o.w = w; o.d = d; o.l = LAPW'(l);
        return o;
    endfunction

    function automatic obs_t cur();
        obs_t o;
        o.c = count; o.b = busy; o.w = wrap; o.d = done; o.l = lap_cnt;
        return o;
    endfunction

    task automatic model_reset();
        int path [10] = '{3, 0, 1, 5, 2, 7, 6, 4, 9, 12};
        for (int i = 0; i < 16; i++) begin tbl[i] = 5; trm[i] = 0; end
        for (int k = 0; k < 10; k++) tbl[path[k]] = path[(k + 1) % 10];
        trm[12] = 1;
        m_count = 3;
        m_lap   = 0;
    endtask

    // Expected per-cycle observations starting the cycle after start is accepted.
    task automatic model_run(int sd, int laps);
        int  c, l;
        bit  t;
        exp_q.delete();
        if (laps == 0) begin
            exp_q.push_back(mk(m_count, 0, 0, 1, m_lap));
            return;
        end
        c = sd; l = 0;
        exp_q.push_back(mk(c, 1, 0, 0, 0));
        for (int g = 0; g < 200; g++) begin
            t = trm[c];
            c = tbl[c];
            if (t) l++;
            if (t && l == laps) begin
                exp_q.push_back(mk(c, 0, 1, 1, l));
                break;
            end
            exp_q.push_back(mk(c, 1, t, 0, l));
        end
        m_count = c;
        m_lap   = l;
    endtask

    // Launch one run, check every cycle of it and the idle cycle that follows.
    task automatic test_run(string name, int sd, int laps);
        model_run(sd, laps);
        start = 1'b1; seed = W'(sd); num_laps = LAPW'(laps);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_checks++;
            if (cur() !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s step %0d: got %h expected %h", name, k, cur(), exp_q[k]);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (cur() !== mk(m_count, 0, 0, 0, m_lap)) begin
            n_fail++;
            $display("FAIL %s idle-after: got %h expected %h", name, cur(), mk(m_count, 0, 0, 0, m_lap));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (cur() !== mk(3, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", cur(), mk(3, 0, 0, 0, 0));
        end
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cfg_err: got %b expected 0", cfg_err);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stop_cfg_err();
        start = 1'b1; seed = W'(3); num_laps = LAPW'(1);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_we = 1'b1; cfg_addr = W'(0); cfg_next = W'(9); cfg_last = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_pulse: got %b expected 1", cfg_err);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_clear: got %b expected 0", cfg_err);
        end
        for (int k = 0; k < 20 && count !== W'(7); k++) begin @(posedge clk); #1; end
        n_checks++;
        if (count !== W'(7)) begin
            n_fail++;
            $display("FAIL stop_reach7: got %0d expected 7 within bound", count);
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        m_count = 7; m_lap = 0;
        n_checks++;
        if (cur() !== mk(7, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL stop_hold: got %h expected %h", cur(), mk(7, 0, 0, 0, 0));
        end
        @(posedge clk); #1;
        n_checks++;
        if (cur() !== mk(7, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL stop_no_done: got %h expected %h", cur(), mk(7, 0, 0, 0, 0));
        end
        // A dropped write leaves 0->1 in place, so this run follows the default path.
        test_run("rerun_after_drop", 0, 1);
    endtask

    task automatic test_custom_table();
        cfg_we = 1'b1; cfg_addr = W'(12); cfg_next = W'(1); cfg_last = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_write_err: got %b expected 0", cfg_err);
        end
        // Second write lands in the same cycle as start and must be seen by the run.
        cfg_addr = W'(6); cfg_next = W'(4); cfg_last = 1'b1;
        start = 1'b1; seed = W'(6); num_laps = LAPW'(1);
        tbl[12] = 1; trm[12] = 1; tbl[6] = 4; trm[6] = 1;
        model_run(6, 1);
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            n_checks++;
            if (cur() !== exp_q[k]) begin
                n_fail++;
                $display("FAIL custom_table step %0d: got %h expected %h", k, cur(), exp_q[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; seed = W'(3); num_laps = LAPW'(1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20 && count !== W'(2); k++) begin @(posedge clk); #1; end
        n_checks++;
        if (count !== W'(2) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_reach2: got count %0d busy %b expected 2 busy 1", count, busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (cur() !== mk(3, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h expected %h", cur(), mk(3, 0, 0, 0, 0));
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %b expected 0", done);
        end
        test_run("post_reset_default", 9, 1);
        test_run("post_reset_seed6", 6, 1);
    endtask

    task automatic test_random();
        int sd, laps;
        for (int r = 0; r < 6; r++) begin
            sd   = $urandom_range(0, 15);
            laps = $urandom_range(1, 3);
            test_run($sformatf("random%0d_s%0d_l%0d", r, sd, laps), sd, laps);
        end
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_next = '0; cfg_last = 1'b0;
        start = 1'b0; seed = '0; num_laps = '0; stop = 1'b0;
        test_reset();
        test_run("default_lap", 3, 1);
        test_run("two_laps_seed15", 15, 2);
        test_run("zero_laps", 5, 0);
        test_stop_cfg_err();
        test_random();
        test_custom_table();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
